ahb_param_reg_slave: RTL and testbench



---
 rtl/ahb_param_reg_slave_pkg.sv | 46 ++++
 rtl/ahb_param_reg_slave_byte_strobe.sv | 30 +++
 rtl/ahb_param_reg_slave.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ahb_param_reg_slave.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_param_reg_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_slv_pkg
// Shared types and constants for the parametrised AHB-Lite register slave:
//   htrans_e       - AHB transfer type encoding
//   HRESP_*        - response encodings
//   fsm_state_e    - data-phase FSM states
//   *_IDX / BASE   - register word indices
//   is_transfer()  - true for NONSEQ/SEQ (an address phase that starts a transfer)
// ---------------------------------------------------------------------------
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } fsm_state_e;

    localparam int STATUS_IDX   = 0;
    localparam int DSIZE_IDX    = 1;
    localparam int PAYLOAD_BASE = 2;

    // IDLE and BUSY never start a transfer; NONSEQ and SEQ do.
    function automatic logic is_transfer(input htrans_e trans);
        logic res;
        case (trans)
            HTRANS_NONSEQ: res = 1'b1;
            HTRANS_SEQ:    res = 1'b1;
            HTRANS_IDLE:   res = 1'b0;
            HTRANS_BUSY:   res = 1'b0;
            default:       res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ahb_param_reg_slave_byte_strobe.sv
// ---------------------------------------------------------------------------
// ahb_byte_strobe
// Maps a transfer size and the low address bits to a little-endian byte-enable
// vector for a DATA_W-bit bus. Sizes at or above the bus width enable all lanes.
// Ports:
//   hsize   in  3      transfer size, log2 of bytes
//   addr_lo in  LGW    byte offset within the bus word
//   strb    out NB     byte enables, bit 0 = byte lane 0 (bits 7:0)
// ---------------------------------------------------------------------------
module ahb_byte_strobe
    import ahb_slv_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LGW    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [2:0]     hsize,
    input  logic [LGW-1:0] addr_lo,
    output logic [NB-1:0]  strb
);

    // A lane is selected when it lies in the same naturally aligned block as the address.
    always_comb begin
        strb = {NB{1'b0}};
        for (int b = 0; b < NB; b++) begin
            strb[b] = ((LGW'(b) >> hsize) == (addr_lo >> hsize)) ? 1'b1 : 1'b0;
        end
    end

endmodule

// File: rtl/ahb_param_reg_slave.sv
// ---------------------------------------------------------------------------
// ahb_param_reg_slave
// Parametrised AHB-Lite register slave exposing STATUS (RO), DATA_SIZE (RW)
// and NUM_PAYLOAD payload registers to the datapath. OKAY transfers take
// WAIT_STATES wait cycles; errors use the two-cycle ERROR response.
// Optional macro AHB_SLV_PERF_CNT_EN adds a read-only PERF word at index
// NUM_PAYLOAD+2 counting completed OKAY transfers.
// Ports:
//   hclk, hreset            clock, synchronous active-high reset
//   hsel_x, hready, hwrite  select, bus ready, write flag
//   haddr, htrans, hsize    address-phase controls
//   hwdata                  write data (data phase)
//   err_status              live datapath status, read through STATUS
//   hrdata, hready_out, hresp  slave response
//   payload                 flattened payload registers, register 0 in LSBs
//   data_size               payload byte count (saturating)
// ---------------------------------------------------------------------------
module ahb_param_reg_slave
    import ahb_slv_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int ADDR_W      = 8,
    parameter  int NUM_PAYLOAD = 4,
    parameter  int WAIT_STATES = 1,
    localparam int DS_W        = $clog2(NUM_PAYLOAD * DATA_W / 8 + 1)
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic                          hsel_x,
    input  logic                          hready,
    input  logic                          hwrite,
    input  logic [ADDR_W-1:0]             haddr,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hsize,
    input  logic [DATA_W-1:0]             hwdata,
    input  logic [1:0]                    err_status,
    output logic [DATA_W-1:0]             hrdata,
    output logic                          hready_out,
    output logic                          hresp,
    output logic [NUM_PAYLOAD*DATA_W-1:0] payload,
    output logic [DS_W-1:0]               data_size
);

    localparam int NB        = DATA_W / 8;
    localparam int LG        = $clog2(NB);
    localparam int LGW       = (NB > 1) ? LG : 1;
    localparam int MAX_BYTES = NUM_PAYLOAD * NB;
    localparam bit WS_NZ_C   = (WAIT_STATES > 0);

    localparam logic [2:0]        WS_C         = 3'(WAIT_STATES);
    localparam logic [2:0]        LG_C         = 3'(LG);
    localparam logic [ADDR_W-1:0] IDX_STATUS_C = ADDR_W'(STATUS_IDX);
    localparam logic [ADDR_W-1:0] IDX_DSIZE_C  = ADDR_W'(DSIZE_IDX);
    localparam logic [ADDR_W-1:0] IDX_PAY_LO_C = ADDR_W'(PAYLOAD_BASE);
    localparam logic [ADDR_W-1:0] IDX_PAY_HI_C = ADDR_W'(PAYLOAD_BASE + NUM_PAYLOAD - 1);
    localparam logic [DATA_W-1:0] MAX_W_C      = DATA_W'(MAX_BYTES);
    localparam logic [DS_W-1:0]   MAX_DS_C     = DS_W'(MAX_BYTES);
`ifdef AHB_SLV_PERF_CNT_EN
    localparam logic [ADDR_W-1:0] IDX_PERF_C   = ADDR_W'(PAYLOAD_BASE + NUM_PAYLOAD);
`endif

    fsm_state_e        state_r;
    fsm_state_e        state_nx_s;
    logic              dphase_r;
    logic [2:0]        wait_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              write_r;
    logic [2:0]        size_r;
    logic [DATA_W-1:0] pay_r [NUM_PAYLOAD];
    logic [DS_W-1:0]   dsize_r;

    logic              done_s;
    logic              hready_s;
    logic              accept_s;
    logic              ok_start_s;
    logic              commit_s;
    logic [ADDR_W-1:0] idx_s;
    logic [ADDR_W-1:0] idx_r_s;
    logic [ADDR_W-1:0] mask_s;
    logic              mapped_s;
    logic              ro_s;
    logic              err_s;
    logic [LGW-1:0]    addr_lo_s;
    logic [NB-1:0]     strb_s;
    logic [DATA_W-1:0] ds_old_s;
    logic [DATA_W-1:0] ds_merge_s;
    logic [DS_W-1:0]   dsize_nx_s;
    logic [DATA_W-1:0] rd_word_s;

    // The last cycle of an OKAY data phase is the one where the wait counter has run out.
    assign done_s     = dphase_r && (wait_cnt_r == WS_C);
    assign hready_s   = (state_r != ST_ERR1) && !(dphase_r && !done_s);
    assign accept_s   = hsel_x && hready && hready_s && is_transfer(htrans_e'(htrans));
    assign ok_start_s = accept_s && !err_s;
    assign commit_s   = done_s && write_r;

    assign idx_s     = haddr >> LG;
    assign idx_r_s   = addr_r >> LG;
    assign mask_s    = ADDR_W'((32'd1 << hsize) - 32'd1);
    assign addr_lo_s = LGW'(addr_r & ADDR_W'(NB - 1));

    assign hready_out = hready_s;
    assign hresp      = ((state_r == ST_ERR1) || (state_r == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata     = (done_s && !write_r) ? rd_word_s : {DATA_W{1'b0}};
    assign data_size  = dsize_r;

    for (genvar g = 0; g < NUM_PAYLOAD; g++) begin : g_flat
        assign payload[g*DATA_W +: DATA_W] = pay_r[g];
    end

    ahb_byte_strobe #(
        .DATA_W (DATA_W)
    ) u_strobe (
        .hsize   (size_r),
        .addr_lo (addr_lo_s),
        .strb    (strb_s)
    );

    // Address-phase decode: is the word mapped, and is it read-only.
    always_comb begin
        mapped_s = 1'b0;
        ro_s     = 1'b0;
        if (idx_s == IDX_STATUS_C) begin
            mapped_s = 1'b1;
            ro_s     = 1'b1;
        end else if (idx_s == IDX_DSIZE_C) begin
            mapped_s = 1'b1;
        end else if ((idx_s >= IDX_PAY_LO_C) && (idx_s <= IDX_PAY_HI_C)) begin
            mapped_s = 1'b1;
`ifdef AHB_SLV_PERF_CNT_EN
        end else if (idx_s == IDX_PERF_C) begin
            mapped_s = 1'b1;
            ro_s     = 1'b1;
`endif
        end else begin
            mapped_s = 1'b0;
            ro_s     = 1'b0;
        end
    end

    // Any of these at accept turns the transfer into an ERROR response.
    always_comb begin
        err_s = !mapped_s
             || (hwrite && ro_s)
             || (hsize > LG_C)
             || ((haddr & mask_s) != {ADDR_W{1'b0}});
    end

    // Next-state logic; an accept is only possible in cycles where we drive hready_out high.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_ERR1: begin
                state_nx_s = ST_ERR2;
            end
            ST_IDLE, ST_WAIT, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nx_s = ST_ERR1;
                    end else if (WS_NZ_C) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else if (hready_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered address-phase controls and wait counter.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r    <= ST_IDLE;
            dphase_r   <= 1'b0;
            wait_cnt_r <= 3'd0;
            addr_r     <= {ADDR_W{1'b0}};
            write_r    <= 1'b0;
            size_r     <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            if (ok_start_s) begin
                dphase_r   <= 1'b1;
                wait_cnt_r <= 3'd0;
                addr_r     <= haddr;
                write_r    <= hwrite;
                size_r     <= hsize;
            end else if (done_s) begin
                dphase_r   <= 1'b0;
                wait_cnt_r <= 3'd0;
            end else if (dphase_r) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end
        end
    end

    // DATA_SIZE write value: byte-merge onto the current value, then saturate.
    always_comb begin
        ds_old_s   = DATA_W'(dsize_r);
        ds_merge_s = ds_old_s;
        for (int b = 0; b < NB; b++) begin
            ds_merge_s[8*b +: 8] = strb_s[b] ? hwdata[8*b +: 8] : ds_old_s[8*b +: 8];
        end
        if (ds_merge_s > MAX_W_C) begin
            dsize_nx_s = MAX_DS_C;
        end else begin
            dsize_nx_s = ds_merge_s[DS_W-1:0];
        end
    end

    // Register file writes happen only on the completion cycle of an OKAY write.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int k = 0; k < NUM_PAYLOAD; k++) begin
                pay_r[k] <= {DATA_W{1'b0}};
            end
            dsize_r <= {DS_W{1'b0}};
        end else if (commit_s) begin
            for (int k = 0; k < NUM_PAYLOAD; k++) begin
                for (int b = 0; b < NB; b++) begin
                    if ((idx_r_s == ADDR_W'(PAYLOAD_BASE + k)) && strb_s[b]) begin
                        pay_r[k][8*b +: 8] <= hwdata[8*b +: 8];
                    end
                end
            end
            if (idx_r_s == IDX_DSIZE_C) begin
                dsize_r <= dsize_nx_s;
            end
        end
    end

`ifdef AHB_SLV_PERF_CNT_EN
    logic [DATA_W-1:0] perf_cnt_r;

    // Completed OKAY transfers, wrapping naturally at all-ones.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            perf_cnt_r <= {DATA_W{1'b0}};
        end else if (done_s) begin
            perf_cnt_r <= perf_cnt_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Read mux on the registered index; STATUS passes err_status straight through.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        if (idx_r_s == IDX_STATUS_C) begin
            rd_word_s = DATA_W'(err_status);
        end else if (idx_r_s == IDX_DSIZE_C) begin
            rd_word_s = DATA_W'(dsize_r);
`ifdef AHB_SLV_PERF_CNT_EN
        end else if (idx_r_s == IDX_PERF_C) begin
            rd_word_s = perf_cnt_r;
`endif
        end else begin
            for (int k = 0; k < NUM_PAYLOAD; k++) begin
                rd_word_s = (idx_r_s == ADDR_W'(PAYLOAD_BASE + k)) ? pay_r[k] : rd_word_s;
            end
        end
    end

endmodule

// File: tb/tb_ahb_param_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_param_reg_slave
// Directed bench for ahb_param_reg_slave at default parameters. The driver
// issues pipelined AHB transfers and pushes the expected response; a monitor
// watches the bus, pops on each completed data phase and compares response,
// wait count and read data. Register outputs are also checked directly.
// ---------------------------------------------------------------------------
module tb_ahb_param_reg_slave;

    localparam int WS = 1;

    logic         hclk;
    logic         hreset;
    logic         hsel_x;
    logic         hready;
    logic         hwrite;
    logic [7:0]   haddr;
    logic [1:0]   htrans;
    logic [2:0]   hsize;
    logic [31:0]  hwdata;
    logic [1:0]   err_status;
    logic [31:0]  hrdata;
    logic         hready_out;
    logic         hresp;
    logic [127:0] payload;
    logic [4:0]   data_size;

    typedef struct {
        int          id;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    ahb_param_reg_slave #(
        .DATA_W      (32),
        .ADDR_W      (8),
        .NUM_PAYLOAD (4),
        .WAIT_STATES (WS)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hsel_x     (hsel_x),
        .hready     (hready),
        .hwrite     (hwrite),
        .haddr      (haddr),
        .htrans     (htrans),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .err_status (err_status),
        .hrdata     (hrdata),
        .hready_out (hready_out),
        .hresp      (hresp),
        .payload    (payload),
        .data_size  (data_size)
    );

    assign hready = hready_out;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns just after the posedge at which the address phase was accepted.
    task automatic wait_accept();
        logic rdy;
        int   n;
        n = 0;
        do begin
            @(negedge hclk);
            rdy = hready_out;
            @(posedge hclk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: hready_out stayed 0 for %0d cycles, expected 1", n);
        end
    endtask

    task automatic xfer(input logic w, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic err, input logic [31:0] rexp);
        exp_t e;
        e.id    = txn_id;
        e.err   = err;
        e.rd    = !w;
        e.rdata = rexp;
        txn_id++;
        hsel_x = 1'b1;
        htrans = 2'd2;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
        exp_q.push_back(e);
        wait_accept();
        hwdata = w ? wd : 32'h0;
        hsel_x = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        hsel_x = 1'b0;
        htrans = 2'd0;
        repeat (n) @(posedge hclk);
        #1;
    endtask

    // Bus monitor / scoreboard checker.
    logic dp_active = 1'b0;
    int   waits     = 0;
    logic hresp_w   = 1'b0;
    always @(negedge hclk) begin
        exp_t e;
        if (hreset) begin
            if (dp_active && exp_q.size() > 0) e = exp_q.pop_front();
            dp_active = 1'b0;
        end else begin
            if (dp_active) begin
                if (hready_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: completion seen with 0 entries queued, expected at least 1");
                    end else begin
                        e = exp_q.pop_front();
                        checks++;
                        if (hresp !== e.err) begin
                            errors++;
                            $display("FAIL txn%0d hresp: got %0b expected %0b", e.id, hresp, e.err);
                        end
                        checks++;
                        if (waits != WS || hresp_w !== e.err) begin
                            errors++;
                            $display("FAIL txn%0d wait: got %0d waits hresp_in_wait %0b expected %0d waits hresp_in_wait %0b",
                                     e.id, waits, hresp_w, WS, e.err);
                        end
                        checks++;
                        if (hrdata !== ((e.rd && !e.err) ? e.rdata : 32'h0)) begin
                            errors++;
                            $display("FAIL txn%0d hrdata: got 0x%08h expected 0x%08h", e.id, hrdata,
                                     (e.rd && !e.err) ? e.rdata : 32'h0);
                        end
                    end
                    dp_active = 1'b0;
                end else begin
                    waits++;
                    if (hresp) hresp_w = 1'b1;
                end
            end
            if (hsel_x && hready_out && htrans[1]) begin
                dp_active = 1'b1;
                waits     = 0;
                hresp_w   = 1'b0;
            end
        end
    end

    initial begin
        hreset = 1'b1; hsel_x = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        haddr = 8'h0; hsize = 3'd0; hwdata = 32'h0; err_status = 2'b00;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("reset_hready_out", {31'd0, hready_out}, 32'd1);
        chk("reset_hresp", {31'd0, hresp}, 32'd0);
        chk("reset_hrdata", hrdata, 32'h0);
        chk("reset_payload0", payload[31:0], 32'h0);
        chk("reset_data_size", {27'd0, data_size}, 32'd0);
        @(posedge hclk); #1;

        // word write then pipelined read
        xfer(1'b1, 8'h08, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer(1'b0, 8'h08, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
        idle(4);
        chk("payload0_word", payload[31:0], 32'hDEADBEEF);

        // byte lane 2 write
        xfer(1'b1, 8'h0A, 3'd0, 32'h00AB0000, 1'b0, 32'h0);
        xfer(1'b0, 8'h08, 3'd2, 32'h0, 1'b0, 32'hDEABBEEF);
        idle(4);
        chk("payload0_byte", payload[31:0], 32'hDEABBEEF);

        // DATA_SIZE saturation
        xfer(1'b1, 8'h04, 3'd2, 32'd100, 1'b0, 32'h0);
        xfer(1'b0, 8'h04, 3'd2, 32'h0, 1'b0, 32'd16);
        idle(4);
        chk("data_size_sat", {27'd0, data_size}, 32'd16);

        // error cases: write STATUS, unmapped, misaligned, oversize
        xfer(1'b1, 8'h00, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer(1'b0, 8'h20, 3'd2, 32'h0, 1'b1, 32'h0);
        xfer(1'b0, 8'h0A, 3'd2, 32'h0, 1'b1, 32'h0);
        xfer(1'b1, 8'h08, 3'd3, 32'h12345678, 1'b1, 32'h0);
        idle(5);
        chk("err_payload0_kept", payload[31:0], 32'hDEABBEEF);
        chk("err_data_size_kept", {27'd0, data_size}, 32'd16);

        // STATUS reflects err_status
        err_status = 2'b10;
        xfer(1'b0, 8'h00, 3'd2, 32'h0, 1'b0, 32'h2);
        // halfword write to upper half of payload1, then word overwrite
        xfer(1'b1, 8'h0E, 3'd1, 32'h5A5A0000, 1'b0, 32'h0);
        xfer(1'b0, 8'h0C, 3'd2, 32'h0, 1'b0, 32'h5A5A0000);
        xfer(1'b1, 8'h0C, 3'd2, 32'h00000011, 1'b0, 32'h0);
        xfer(1'b0, 8'h0C, 3'd2, 32'h0, 1'b0, 32'h00000011);
        idle(4);
        chk("payload1_word", payload[63:32], 32'h00000011);

        // reset in the middle of a write's wait state
        xfer(1'b1, 8'h10, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
        hreset = 1'b1;
        @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rst_mid_hready_out", {31'd0, hready_out}, 32'd1);
        chk("rst_mid_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_mid_payload2", payload[95:64], 32'h0);
        chk("rst_mid_payload0", payload[31:0], 32'h0);
        chk("rst_mid_data_size", {27'd0, data_size}, 32'd0);
        @(posedge hclk); #1;

        // three OKAY transfers and one error, then PERF
        xfer(1'b1, 8'h08, 3'd2, 32'h1, 1'b0, 32'h0);
        xfer(1'b1, 8'h0C, 3'd2, 32'h2, 1'b0, 32'h0);
        xfer(1'b0, 8'h08, 3'd2, 32'h0, 1'b0, 32'h1);
        xfer(1'b1, 8'h00, 3'd2, 32'h5, 1'b1, 32'h0);
`ifdef AHB_SLV_PERF_CNT_EN
        xfer(1'b0, 8'h18, 3'd2, 32'h0, 1'b0, 32'd3);
`else
        xfer(1'b0, 8'h18, 3'd2, 32'h0, 1'b1, 32'h0);
`endif
        idle(6);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
